// File: rtl/mls_seq_ctrl.sv
// Run sequencer for the MLS excitation generator: latches a measurement config on start,
// sequences generator reset/enable, counts sequence periods and reports busy/done/timeout status.
module mls_seq_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int PER_W      = 16,
  parameter int TO_W       = 24
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [3:0]       cfg_order_i,
  input  logic [7:0]       cfg_div_i,
  input  logic [2:0]       cfg_rep_i,
  input  logic [PER_W-1:0] cfg_nper_i,
  input  logic [TO_W-1:0]  cfg_timeout_i,
  input  logic             gen_flag_i,
  output logic             gen_srst_o,
  output logic             gen_en_o,
  output logic [3:0]       gen_order_o,
  output logic [7:0]       gen_div_o,
  output logic [2:0]       gen_rep_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [PER_W-1:0] per_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_GRST, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       rst_cnt;
  logic             flag_q;
  logic [TO_W-1:0]  tmo_cnt, tmo_q;
  logic [PER_W-1:0] nper_q, per_nxt;
  logic             accept, flag_edge, complete, tmo_hit;

  always_comb begin
    accept    = (state == S_IDLE) && start_i && !abort_i;
    flag_edge = (state == S_RUN) && gen_flag_i && !flag_q;
    per_nxt   = (&per_cnt_o) ? per_cnt_o : per_cnt_o + 1'b1;
    complete  = flag_edge && (per_nxt == nper_q);
    // an edge on the expiry cycle still counts, so it masks the timeout
    tmo_hit   = !flag_edge && (tmo_q != '0) && (tmo_cnt >= tmo_q);
    state_n   = state;
    case (state)
      S_IDLE: if (accept) state_n = S_GRST;
      S_GRST: begin
        if (abort_i)                                state_n = S_IDLE;
        else if (rst_cnt == 4'(RST_CYCLES - 1))     state_n = (nper_q != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (abort_i || tmo_hit) state_n = S_IDLE;
        else if (complete)      state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      flag_q      <= 1'b0;
      tmo_cnt     <= '0;
      tmo_q       <= '0;
      nper_q      <= '0;
      gen_srst_o  <= 1'b1;
      gen_en_o    <= 1'b0;
      gen_order_o <= '0;
      gen_div_o   <= '0;
      gen_rep_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      per_cnt_o   <= '0;
    end else begin
      state      <= state_n;
      // outputs follow the next state so every port is a flop
      gen_srst_o <= (state_n != S_RUN);
      gen_en_o   <= (state_n == S_RUN);
      busy_o     <= (state_n != S_IDLE);
      done_o     <= (state_n == S_DONE);
      if (accept) begin
        gen_order_o <= (cfg_order_i > 4'd7) ? 4'd7 : cfg_order_i;
        gen_div_o   <= cfg_div_i;
        gen_rep_o   <= cfg_rep_i;
        nper_q      <= cfg_nper_i;
        tmo_q       <= cfg_timeout_i;
        per_cnt_o   <= '0;
        err_o       <= 1'b0;
        rst_cnt     <= '0;
      end
      if (state == S_GRST) begin
        rst_cnt <= rst_cnt + 1'b1;
        flag_q  <= 1'b0;
        tmo_cnt <= '0;
      end
      if (state == S_RUN) begin
        flag_q <= gen_flag_i;
        if (flag_edge)        tmo_cnt <= '0;
        else if (~&tmo_cnt)   tmo_cnt <= tmo_cnt + 1'b1;
        // abort freezes the count and suppresses the error
        if (!abort_i) begin
          if (flag_edge) per_cnt_o <= per_nxt;
          if (tmo_hit)   err_o     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mls_seq_ctrl.sv
// Randomized scoreboard bench for mls_seq_ctrl: per-run outcome predicted from flag/abort schedules,
// checked by a monitor at the end of every busy window.
module tb_mls_seq_ctrl;
  localparam int RST   = 4;
  localparam int PER_W = 16;
  localparam int TO_W  = 24;
  localparam int MAXL  = 1024;
  localparam int R     = 1 + RST;

  logic             clk = 1'b0, srst = 1'b1, start_i = 1'b0, abort_i = 1'b0, gen_flag_i = 1'b0;
  logic [3:0]       cfg_order_i = '0;
  logic [7:0]       cfg_div_i = '0;
  logic [2:0]       cfg_rep_i = '0;
  logic [PER_W-1:0] cfg_nper_i = '0;
  logic [TO_W-1:0]  cfg_timeout_i = '0;
  logic             gen_srst_o, gen_en_o, busy_o, done_o, err_o;
  logic [3:0]       gen_order_o;
  logic [7:0]       gen_div_o;
  logic [2:0]       gen_rep_o;
  logic [PER_W-1:0] per_cnt_o;

  mls_seq_ctrl #(.RST_CYCLES(RST), .PER_W(PER_W), .TO_W(TO_W)) dut (
    .clk(clk), .srst(srst), .start_i(start_i), .abort_i(abort_i),
    .cfg_order_i(cfg_order_i), .cfg_div_i(cfg_div_i), .cfg_rep_i(cfg_rep_i),
    .cfg_nper_i(cfg_nper_i), .cfg_timeout_i(cfg_timeout_i), .gen_flag_i(gen_flag_i),
    .gen_srst_o(gen_srst_o), .gen_en_o(gen_en_o), .gen_order_o(gen_order_o),
    .gen_div_o(gen_div_o), .gen_rep_o(gen_rep_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .per_cnt_o(per_cnt_o)
  );

  typedef struct {
    int         t_start;
    int         en_rise;
    int         en_cnt;
    int         srst_cnt;
    int         done_cyc;
    int         fall;
    bit         err;
    int         per;
    logic [3:0] ord;
    logic [7:0] div;
    logic [2:0] rep;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, total = 0, bad = 0;
  bit   flag_a[MAXL], abort_a[MAXL], start_a[MAXL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: gathers what happened inside each busy window, compares when busy drops
  bit   busy_d = 1'b0, srst_prev = 1'b1;
  int   m_rise, m_enr, m_enc, m_src, m_done, m_donen;
  exp_t m_e;
  always @(negedge clk) begin
    if (!srst_prev) begin
      if (busy_o && !busy_d) begin
        m_rise = cyc; m_enr = -1; m_enc = 0; m_src = 0; m_done = -1; m_donen = 0;
      end
      if (busy_o) begin
        if (gen_en_o) begin
          m_enc++;
          if (m_enr < 0) m_enr = cyc;
        end
        if (gen_srst_o) m_src++;
        if (done_o) begin
          m_donen++;
          if (m_done < 0) m_done = cyc;
        end
      end
      if (!busy_o && busy_d) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_end: busy dropped at cycle %0d with no run pending", cyc);
        end else begin
          m_e = q.pop_front();
          chk("busy_rise", m_rise, m_e.t_start + 1);
          chk("en_rise", m_enr, m_e.en_rise);
          chk("en_cycles", m_enc, m_e.en_cnt);
          chk("gsrst_cycles", m_src, m_e.srst_cnt);
          chk("done_cycle", m_done, m_e.done_cyc);
          chk("done_pulses", m_donen, (m_e.done_cyc >= 0) ? 1 : 0);
          chk("end_cycle", cyc, m_e.fall);
          chk("err", err_o, m_e.err);
          chk("per_cnt", per_cnt_o, m_e.per);
          chk("order", gen_order_o, m_e.ord);
          chk("div", gen_div_o, m_e.div);
          chk("rep", gen_rep_o, m_e.rep);
          chk("idle_en", gen_en_o, 0);
          chk("idle_gsrst", gen_srst_o, 1);
        end
      end
    end
    busy_d    = busy_o;
    srst_prev = srst;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_gsrst"}, gen_srst_o, 1);
    chk({tag, "_en"}, gen_en_o, 0);
    chk({tag, "_order"}, gen_order_o, 0);
    chk({tag, "_div"}, gen_div_o, 0);
    chk({tag, "_rep"}, gen_rep_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_per"}, per_cnt_o, 0);
  endtask

  task automatic plan_clear(input int guard);
    for (int i = 0; i < MAXL; i++) begin
      flag_a[i] = 1'b0; abort_a[i] = 1'b0; start_a[i] = 1'b0;
    end
    abort_a[guard] = 1'b1;
  endtask

  task automatic add_pulse(input int at, input int w);
    for (int i = at; i < at + w && i < MAXL; i++) flag_a[i] = 1'b1;
  endtask

  task automatic rand_cfg();
    cfg_order_i   = 4'($urandom_range(0, 15));
    cfg_div_i     = 8'($urandom);
    cfg_rep_i     = 3'($urandom);
    cfg_nper_i    = PER_W'($urandom);
    cfg_timeout_i = TO_W'($urandom);
  endtask

  // Offsets are cycles after the accepted start (offset 0). The run enters RUN at offset R.
  task automatic execute(input logic [3:0] ord, input logic [7:0] div, input logic [2:0] rep,
                         input int nper, input int tmo);
    exp_t e;
    int   cnt, rf, fall, t0;
    bit   prevf, edge_s;
    cnt = 0; rf = R; prevf = 1'b0; fall = -1;
    e.en_rise = -1; e.en_cnt = 0; e.done_cyc = -1; e.err = 1'b0;
    for (int c = 1; c < MAXL - 2 && fall < 0; c++) begin
      if (nper == 0 && c == R) begin
        e.done_cyc = c; fall = c + 1;
      end else begin
        if (c >= R) begin
          e.en_rise = R; e.en_cnt++;
        end
        if (abort_a[c]) fall = c + 1;
        else if (c >= R) begin
          edge_s = flag_a[c] && !prevf;
          prevf  = flag_a[c];
          if (edge_s) begin
            cnt++; rf = c + 1;
            if (cnt == nper) begin
              e.done_cyc = c + 1; fall = c + 2;
            end
          end else if (tmo != 0 && c - rf >= tmo) begin
            e.err = 1'b1; fall = c + 1;
          end
        end
      end
    end
    for (int c = 1; c < fall; c++) start_a[c] = ($urandom_range(0, 7) == 0);
    @(posedge clk); #1;
    t0 = cyc;
    e.t_start  = t0;
    e.fall     = t0 + fall;
    e.srst_cnt = fall - 1 - e.en_cnt;
    if (e.en_rise >= 0)  e.en_rise  += t0;
    if (e.done_cyc >= 0) e.done_cyc += t0;
    e.per = cnt;
    e.ord = (ord > 4'd7) ? 4'd7 : ord;
    e.div = div;
    e.rep = rep;
    q.push_back(e);
    start_i = 1'b1; abort_i = 1'b0; gen_flag_i = flag_a[0];
    cfg_order_i = ord; cfg_div_i = div; cfg_rep_i = rep;
    cfg_nper_i = PER_W'(nper); cfg_timeout_i = TO_W'(tmo);
    for (int c = 1; c <= fall; c++) begin
      @(posedge clk); #1;
      start_i = start_a[c]; abort_i = abort_a[c]; gen_flag_i = flag_a[c];
      rand_cfg();
    end
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0; gen_flag_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    srst = 1'b0;

    plan_clear(MAXL - 5);
    add_pulse(R + 254, 1); add_pulse(R + 509, 1); add_pulse(R + 764, 1);
    execute(4'd2, 8'd0, 3'd0, 3, 0);

    plan_clear(MAXL - 5);
    execute(4'd5, 8'h11, 3'd3, 0, 0);

    plan_clear(MAXL - 5);
    execute(4'd1, 8'd3, 3'd1, 1, 100);
    chk("err_sticky", err_o, 1);
    chk("err_idle_busy", busy_o, 0);

    plan_clear(MAXL - 5);
    add_pulse(R + 10, 2); add_pulse(R + 30, 2); add_pulse(R + 50, 2); add_pulse(R + 70, 2);
    abort_a[R + 20] = 1'b1;
    execute(4'd3, 8'd1, 3'd2, 4, 0);

    plan_clear(MAXL - 5);
    add_pulse(R + 3, 1);
    execute(4'd12, 8'hA5, 3'd7, 1, 0);

    plan_clear(MAXL - 5);
    add_pulse(R + 5, 10); add_pulse(R + 40, 10);
    execute(4'd4, 8'd2, 3'd1, 2, 50);

    // start together with abort in IDLE must be ignored
    @(posedge clk); #1;
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    chk("start_abort_idle", busy_o, 0);

    for (int n = 0; n < 40; n++) begin
      int pos, ne, w;
      plan_clear(300);
      pos = $urandom_range(1, R + 30);
      ne  = $urandom_range(0, 7);
      for (int k = 0; k < ne; k++) begin
        w = $urandom_range(1, 6);
        add_pulse(pos, w);
        pos += w + $urandom_range(1, 30);
      end
      if ($urandom_range(0, 4) == 0) abort_a[$urandom_range(1, 120)] = 1'b1;
      execute(4'($urandom_range(0, 15)), 8'($urandom), 3'($urandom), $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 40));
    end

    // srst in the middle of a run returns everything to reset values
    @(posedge clk); #1;
    cfg_order_i = 4'd6; cfg_div_i = 8'h3C; cfg_rep_i = 3'd5; cfg_nper_i = 16'd5; cfg_timeout_i = '0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (R + 3) @(posedge clk);
    #1;
    gen_flag_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    gen_flag_i = 1'b0;
    chk("midrun_per_before_srst", per_cnt_o, 1);
    srst = 1'b1;
    @(posedge clk); #1;
    check_reset("midrun_srst");
    srst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("after_srst_busy", busy_o, 0);
    chk("pending_runs", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
